// File: rtl/multicycle_controller.sv
// Control FSM for the shared multicycle RISC-V datapath, including ALU-control and immediate decode.
// Define MCU_BNE_EN to add bne support to the BRANCH state; by default only beq is accepted.
module multicycle_controller #(
    parameter int unsigned OP_WIDTH       = 7,
    parameter int unsigned FUNCT3_WIDTH   = 3,
    parameter int unsigned ALU_CTRL_WIDTH = 3,
    parameter int unsigned IMM_SRC_WIDTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [OP_WIDTH-1:0]       op,
    input  logic [FUNCT3_WIDTH-1:0]   funct3,
    input  logic                      funct7_5,
    input  logic                      Zero,
    input  logic                      mem_ready,
    output logic                      PCWrite,
    output logic                      AdrSrc,
    output logic                      MemWrite,
    output logic                      IRWrite,
    output logic [1:0]                ResultSrc,
    output logic [1:0]                ALUSrcA,
    output logic [1:0]                ALUSrcB,
    output logic [IMM_SRC_WIDTH-1:0]  ImmSrc,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
    output logic                      RegWrite,
    output logic                      instr_done,
    output logic                      illegal
);

    localparam logic [3:0] StFetch    = 4'd0;
    localparam logic [3:0] StDecode   = 4'd1;
    localparam logic [3:0] StMemAdr   = 4'd2;
    localparam logic [3:0] StMemRead  = 4'd3;
    localparam logic [3:0] StMemWb    = 4'd4;
    localparam logic [3:0] StMemWrite = 4'd5;
    localparam logic [3:0] StExecR    = 4'd6;
    localparam logic [3:0] StExecI    = 4'd7;
    localparam logic [3:0] StJal      = 4'd8;
    localparam logic [3:0] StAluWb    = 4'd9;
    localparam logic [3:0] StBranch   = 4'd10;
    localparam logic [3:0] StTrap     = 4'd11;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    logic [3:0] state_q, state_d;
    logic [1:0] alu_op;
    logic       branch_ok;
    logic       branch_taken;

`ifdef MCU_BNE_EN
    assign branch_ok    = (funct3[2:0] == 3'b000) || (funct3[2:0] == 3'b001);
    assign branch_taken = funct3[0] ? ~Zero : Zero;
`else
    assign branch_ok    = (funct3[2:0] == 3'b000);
    assign branch_taken = Zero;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StTrap;
        case (state_q)
            StFetch:    state_d = mem_ready ? StDecode : StFetch;
            StDecode: begin
                case (op[6:0])
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpBranch:        state_d = branch_ok ? StBranch : StTrap;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
            StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = mem_ready ? StFetch : StMemWrite;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StJal:      state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StTrap:     state_d = StTrap;
            default:    state_d = StTrap;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_op     = 2'b00;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            StFetch: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
            end
            StMemWb: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            StMemWrite: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
            end
            StExecR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            StExecI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            StJal: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            StAluWb: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b01;
                PCWrite    = branch_taken;
                instr_done = 1'b1;
            end
            StTrap: begin
                illegal = 1'b1;
            end
            default: ;
        endcase
        // Reset forces every strobe low even though the state already reads FETCH.
        if (!rst_n) begin
            PCWrite    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3[2:0])
                    3'b000:  ALUControl = (op[5] && funct7_5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op[6:0])
            OpStore:  ImmSrc = 2'b01;
            OpBranch: ImmSrc = 2'b10;
            OpJal:    ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; every output is packed into one vector per cycle.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int checks   = 0;
    int failures = 0;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: pcw adr mw irw rsrc srca srcb imm aluctl rw done ill
    function automatic logic [17:0] pk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] imm, input logic [2:0] alu,
                                       input logic rw, input logic done, input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, done, ill};
    endfunction

    function automatic logic [17:0] outs();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
                ALUControl, RegWrite, instr_done, illegal};
    endfunction

    task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
        end
    endtask

    // Settle after the negedge-driven inputs, compare, then move past the next rising edge.
    task automatic step(input string tag, input logic [17:0] exp);
        #1;
        check_eq(tag, outs(), exp);
        @(negedge clk);
    endtask

    task automatic settle_check(input string tag, input logic [17:0] exp);
        #1;
        check_eq(tag, outs(), exp);
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op       = o;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        settle_check("rst_pulse", pk(0, 0, 0, 0, 2, 0, 2, ImmSrc, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        Zero      = 1'b0;
        set_instr(7'b0000011, 3'b010, 1'b0);
        repeat (2) @(negedge clk);
        settle_check("reset", pk(0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // lw, mem_ready high: five cycles
        step("lw_fetch",   pk(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0));
        step("lw_decode",  pk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        step("lw_memadr",  pk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        step("lw_memread", pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("lw_memwb",   pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0));

        // sw with three stalled MEMWRITE cycles
        set_instr(7'b0100011, 3'b010, 1'b0);
        step("sw_fetch",  pk(1, 0, 0, 1, 2, 0, 2, 1, 0, 0, 0, 0));
        step("sw_decode", pk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        step("sw_memadr", pk(0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("sw_wait", pk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        end
        mem_ready = 1'b1;
        step("sw_done", pk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        mem_ready = 1'b0;
        step("fetch_stall", pk(0, 0, 0, 0, 2, 0, 2, 1, 0, 0, 0, 0));
        mem_ready = 1'b1;

        // sub (R-type, funct7_5 = 1)
        set_instr(7'b0110011, 3'b000, 1'b1);
        step("sub_fetch",  pk(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0));
        step("sub_decode", pk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        step("sub_execr",  pk(0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0));
        step("sub_aluwb",  pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));

        // addi with bit30 set stays add
        set_instr(7'b0010011, 3'b000, 1'b1);
        step("addi_fetch",  pk(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0));
        step("addi_decode", pk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        step("addi_execi",  pk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        step("addi_aluwb",  pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));

        // and / or / slt decode in EXECR
        set_instr(7'b0110011, 3'b111, 1'b0);
        repeat (2) @(negedge clk);
        step("and_execr", pk(0, 0, 0, 0, 0, 2, 0, 0, 2, 0, 0, 0));
        @(negedge clk);
        set_instr(7'b0110011, 3'b110, 1'b0);
        repeat (2) @(negedge clk);
        step("or_execr", pk(0, 0, 0, 0, 0, 2, 0, 0, 3, 0, 0, 0));
        @(negedge clk);
        set_instr(7'b0010011, 3'b010, 1'b0);
        repeat (2) @(negedge clk);
        step("slti_execi", pk(0, 0, 0, 0, 0, 2, 1, 0, 5, 0, 0, 0));
        step("slti_aluwb", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        step("jal_fetch",  pk(1, 0, 0, 1, 2, 0, 2, 3, 0, 0, 0, 0));
        step("jal_decode", pk(0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0));
        step("jal_jal",    pk(1, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0));
        step("jal_aluwb",  pk(0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 1, 0));

        // beq: PCWrite follows Zero within the BRANCH cycle
        set_instr(7'b1100011, 3'b000, 1'b0);
        step("beq_fetch",  pk(1, 0, 0, 1, 2, 0, 2, 2, 0, 0, 0, 0));
        step("beq_decode", pk(0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0));
        Zero = 1'b0;
        settle_check("beq_nt", pk(0, 0, 0, 0, 0, 2, 0, 2, 1, 0, 1, 0));
        Zero = 1'b1;
        step("beq_t", pk(1, 0, 0, 0, 0, 2, 0, 2, 1, 0, 1, 0));

        // bne
        set_instr(7'b1100011, 3'b001, 1'b0);
        step("bne_fetch",  pk(1, 0, 0, 1, 2, 0, 2, 2, 0, 0, 0, 0));
        step("bne_decode", pk(0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0));
`ifdef MCU_BNE_EN
        Zero = 1'b1;
        settle_check("bne_nt", pk(0, 0, 0, 0, 0, 2, 0, 2, 1, 0, 1, 0));
        Zero = 1'b0;
        step("bne_t", pk(1, 0, 0, 0, 0, 2, 0, 2, 1, 0, 1, 0));
`else
        step("bne_trap", pk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1));
`endif
        pulse_reset();

        // Opcode 0 traps and stays trapped
        set_instr(7'b0000000, 3'b000, 1'b0);
        step("ill_fetch",  pk(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0));
        step("ill_decode", pk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 12; i++) begin
            mem_ready = i[0];
            Zero      = i[1];
            step("trap_hold", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        mem_ready = 1'b1;
        pulse_reset();

        // Reset asserted during MEMREAD aborts the load
        set_instr(7'b0000011, 3'b010, 1'b0);
        step("ab_fetch",  pk(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0));
        step("ab_decode", pk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        step("ab_memadr", pk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        mem_ready = 1'b0;
        settle_check("ab_memread", pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        settle_check("ab_reset", pk(0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step("ab_refetch",  pk(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0));
        step("ab_redecode", pk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state controller that sequences the shared multicycle RISC-V datapath: one ALU, one unified instruction/data memory port, PC, IR, OldPC, A/B, ALUOut and Data registers. Every instruction is walked through fetch, decode, execute, memory and writeback states. The block drives all mux selects and write strobes, stalls on a memory-ready handshake, and traps on unsupported encodings. It embeds the ALU-control decode, so `ALUControl` is produced here directly.

## Interface
Parameters:
- `OP_WIDTH`, 7, opcode width
- `FUNCT3_WIDTH`, 3, funct3 width
- `ALU_CTRL_WIDTH`, 3, ALU control width
- `IMM_SRC_WIDTH`, 2, immediate-select width

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `op`  in  `OP_WIDTH`  opcode from IR
- `funct3`  in  `FUNCT3_WIDTH`  from IR
- `funct7_5`  in  1  IR bit 30
- `Zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `PCWrite`  out  1  PC load strobe
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result
- `MemWrite`  out  1  memory write request
- `IRWrite`  out  1  IR and OldPC load strobe
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = A
- `ALUSrcB`  out  2  ALU B select: 00 = B, 01 = ImmExt, 10 = 4
- `ImmSrc`  out  `IMM_SRC_WIDTH`  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- `ALUControl`  out  `ALU_CTRL_WIDTH`  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- `RegWrite`  out  1  register-file write strobe
- `instr_done`  out  1  one-cycle pulse on the last cycle of each retired instruction
- `illegal`  out  1  high while the controller is in TRAP

## Operation
State encoding and register:
- 4-bit state register; asynchronous reset to FETCH.
- Any unused state encoding goes to TRAP.

Default output values (every output not listed for a state takes these):
- All strobes 0, all selects 00, `ALUControl` = 000.

ALUOp decode (internal to the block):
- ALUOp 00 → add.
- ALUOp 01 → sub.
- ALUOp 10 → decode funct3:
  - funct3 000 → sub if `op[5]` and `funct7_5` are both 1, otherwise add.
  - funct3 010 → slt.
  - funct3 110 → or.
  - funct3 111 → and.
  - any other funct3 → add.

ImmSrc decode:
- Combinational from `op` in every state.
- 0100011 → S, 1100011 → B, 1101111 → J, all other opcodes → I.

States, their outputs, and next state:
- FETCH
  - Outputs: `AdrSrc` = 0, `ALUSrcA` = 00, `ALUSrcB` = 10, ALUOp 00, `ResultSrc` = 10.
  - `IRWrite` = `PCWrite` = `mem_ready`.
  - Next: DECODE if `mem_ready`, else FETCH.
- DECODE
  - Outputs: `ALUSrcA` = 01, `ALUSrcB` = 01, ALUOp 00 (branch target into ALUOut).
  - Next, by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100011 → BRANCH, only if funct3 is supported (see Configuration)
    - anything else → TRAP
- MEMADR
  - Outputs: `ALUSrcA` = 10, `ALUSrcB` = 01, ALUOp 00.
  - Next: MEMWRITE if `op[5]`, else MEMREAD.
- MEMREAD
  - Outputs: `AdrSrc` = 1, `ResultSrc` = 00.
  - Next: MEMWB if `mem_ready`, else MEMREAD.
- MEMWB
  - Outputs: `ResultSrc` = 01, `RegWrite` = 1, `instr_done` = 1.
  - Next: FETCH.
- MEMWRITE
  - Outputs: `AdrSrc` = 1, `ResultSrc` = 00, `MemWrite` = 1, held until `mem_ready`.
  - `instr_done` = `mem_ready`.
  - Next: FETCH if `mem_ready`, else MEMWRITE.
- EXECR
  - Outputs: `ALUSrcA` = 10, `ALUSrcB` = 00, ALUOp 10.
  - Next: ALUWB.
- EXECI
  - Outputs: `ALUSrcA` = 10, `ALUSrcB` = 01, ALUOp 10.
  - Next: ALUWB.
- JAL
  - Outputs: `ALUSrcA` = 01, `ALUSrcB` = 10, ALUOp 00, `ResultSrc` = 00, `PCWrite` = 1.
  - Next: ALUWB.
- ALUWB
  - Outputs: `ResultSrc` = 00, `RegWrite` = 1, `instr_done` = 1.
  - Next: FETCH.
- BRANCH
  - Outputs: `ALUSrcA` = 10, `ALUSrcB` = 00, ALUOp 01, `ResultSrc` = 00, `instr_done` = 1.
  - `PCWrite` = branch-taken condition (see Configuration).
  - Next: FETCH.
- TRAP
  - Outputs: defaults, plus `illegal` = 1.
  - Next: TRAP; exited only by reset.

## Timing
Latency with `mem_ready` held high:
- lw: 5 cycles.
- sw, R-type, I-type ALU, jal: 4 cycles.
- Branch: 3 cycles.
- Each low `mem_ready` cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.

Output timing:
- Outputs are combinational from the state.
- `PCWrite` and `IRWrite` in FETCH, `MemWrite`/`instr_done` in MEMWRITE, and `PCWrite` in BRANCH also depend on same-cycle inputs.
- No output is registered.

Memory handshake rules:
- The controller never deasserts `MemWrite` or changes `AdrSrc` while an access is pending.
- Address and write request stay stable until `mem_ready`.

Reset:
- While `rst_n` = 0, all strobes are forced to 0 (`PCWrite`, `IRWrite`, `MemWrite`, `RegWrite`, `instr_done`), `illegal` = 0, and the selects show FETCH values.
- Reset asserted mid-instruction aborts the instruction immediately.
- No write strobe fires in the cycle reset is released.
- The first edge after release evaluates FETCH.

Simultaneous events:
- `mem_ready` arriving in the first FETCH cycle loads IR and PC in that same cycle.

## Configuration
- `MCU_BNE_EN` defined:
  - BRANCH accepts funct3 000 (beq) and 001 (bne).
  - Branch taken: `PCWrite` = `Zero` for beq, `~Zero` for bne.
  - Other funct3 values go DECODE → TRAP.
- `MCU_BNE_EN` undefined:
  - Only beq is supported; `PCWrite` = `Zero`.
  - funct3 ≠ 000 goes DECODE → TRAP.

## Test plan
- Reset, then lw with `mem_ready` = 1: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; `RegWrite` = 1 only in cycle 5; `instr_done` pulses once.
- sw with `mem_ready` low for 3 MEMWRITE cycles: `MemWrite` = 1 and `AdrSrc` = 1 for 4 consecutive cycles; FETCH follows; `instr_done` only in the final cycle.
- sub (0110011, funct3 000, `funct7_5` = 1): `ALUControl` = 001 in EXECR. Then addi with bit30 = 1: `ALUControl` = 000.
- beq with `Zero` = 1 gives `PCWrite` = 1 in BRANCH; with `Zero` = 0 gives `PCWrite` = 0. With the macro defined, bne gives the inverse; with it undefined, bne → `illegal` = 1.
- Opcode 0000000 after fetch: TRAP entered; `illegal` stays 1 and strobes stay 0 for 10 or more cycles until `rst_n` is pulsed.
- `rst_n` asserted in MEMREAD: all strobes drop in the same cycle; after release, the FETCH sequence restarts with no `RegWrite`.
